// File: rtl/joy2quad_multi.sv
// joy2quad_multi: per-channel left/right controls to emulated rotary-encoder A/B phases.
// Define JOY2QUAD_ACCEL_EN to enable the per-channel speed ramp (period halves per level).
module joy2quad_multi #(
   parameter int CHANNELS    = 2,
   parameter int DIV_W       = 16,
   parameter int ACCEL_STEPS = 16,
   parameter int ACCEL_MAX   = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DIV_W-1:0]      clkdiv,
   input  logic [CHANNELS-1:0]   left,
   input  logic [CHANNELS-1:0]   right,
   output logic [2*CHANNELS-1:0] steer,
   output logic [CHANNELS-1:0]   moving
);

   typedef enum logic [1:0] {
      DIR_IDLE = 2'b00,
      DIR_CW   = 2'b01,
      DIR_CCW  = 2'b10
   } dir_e;

   localparam int LVL_W = (ACCEL_MAX > 0) ? $clog2(ACCEL_MAX + 1) : 1;

   logic [CHANNELS-1:0][1:0]       dir_q, dir_d;
   logic [CHANNELS-1:0][1:0]       prev_q, prev_d;
   logic [CHANNELS-1:0][DIV_W-1:0] cnt_q, cnt_d;
   logic [CHANNELS-1:0][1:0]       phase_q, phase_d;
   logic [CHANNELS-1:0]            moving_q, moving_d;
   logic [CHANNELS-1:0]            step_s;
   logic [CHANNELS-1:0][LVL_W-1:0] lvl_s;
   logic [CHANNELS-1:0][DIV_W-1:0] limit_s;

   function automatic dir_e decode_dir(input logic l, input logic r);
      dir_e d;
      case ({l, r})
         2'b01:   d = DIR_CW;
         2'b10:   d = DIR_CCW;
         default: d = DIR_IDLE;
      endcase
      return d;
   endfunction

   // Gray walk 00->01->11->10 for CW, reverse for CCW.
   function automatic logic [1:0] step_phase(input logic [1:0] ph, input logic cw);
      logic [1:0] n;
      case (ph)
         2'b00:   n = cw ? 2'b01 : 2'b10;
         2'b01:   n = cw ? 2'b11 : 2'b00;
         2'b11:   n = cw ? 2'b10 : 2'b01;
         2'b10:   n = cw ? 2'b00 : 2'b11;
         default: n = 2'b00;
      endcase
      return n;
   endfunction

   // Effective period minus one and the per-channel step strobe.
   always_comb begin
      logic [DIV_W-1:0] shifted_v;
      shifted_v = '0;
      limit_s   = '0;
      step_s    = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         shifted_v = clkdiv >> lvl_s[ch];
         if (shifted_v == '0) begin
            limit_s[ch] = '0;
         end else begin
            limit_s[ch] = shifted_v - DIV_W'(1);
         end
         // ">=" lets a shrinking period take effect at once instead of wrapping.
         step_s[ch] = (dir_q[ch] != DIR_IDLE) && (dir_q[ch] == prev_q[ch]) &&
                      (cnt_q[ch] >= limit_s[ch]);
      end
   end

   // Direction capture, counter and phase next-state.
   always_comb begin
      dir_d    = dir_q;
      prev_d   = prev_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      moving_d = moving_q;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         dir_d[ch]    = decode_dir(left[ch], right[ch]);
         moving_d[ch] = (decode_dir(left[ch], right[ch]) != DIR_IDLE);
         prev_d[ch]   = dir_q[ch];
         if ((dir_q[ch] == DIR_IDLE) || (dir_q[ch] != prev_q[ch])) begin
            cnt_d[ch] = '0;
         end else if (step_s[ch]) begin
            cnt_d[ch]   = '0;
            phase_d[ch] = step_phase(phase_q[ch], dir_q[ch] == DIR_CW);
         end else begin
            cnt_d[ch] = cnt_q[ch] + DIV_W'(1);
         end
      end
   end

   // Main state registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         dir_q    <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         phase_q  <= '0;
         moving_q <= '0;
      end else begin
         dir_q    <= dir_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         moving_q <= moving_d;
      end
   end

`ifdef JOY2QUAD_ACCEL_EN
   localparam int TALLY_W = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;

   logic [CHANNELS-1:0][LVL_W-1:0]   lvl_q, lvl_d;
   logic [CHANNELS-1:0][TALLY_W-1:0] tally_q, tally_d;

   assign lvl_s = lvl_q;

   // Acceleration level and same-direction step tally.
   always_comb begin
      lvl_d   = lvl_q;
      tally_d = tally_q;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         if ((dir_q[ch] == DIR_IDLE) || (dir_q[ch] != prev_q[ch])) begin
            lvl_d[ch]   = '0;
            tally_d[ch] = '0;
         end else if (step_s[ch]) begin
            if (tally_q[ch] == TALLY_W'(ACCEL_STEPS - 1)) begin
               tally_d[ch] = '0;
               if (lvl_q[ch] != LVL_W'(ACCEL_MAX)) begin
                  lvl_d[ch] = lvl_q[ch] + LVL_W'(1);
               end else begin
                  lvl_d[ch] = lvl_q[ch];
               end
            end else begin
               tally_d[ch] = tally_q[ch] + TALLY_W'(1);
            end
         end else begin
            lvl_d[ch]   = lvl_q[ch];
            tally_d[ch] = tally_q[ch];
         end
      end
   end

   // Acceleration registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         lvl_q   <= '0;
         tally_q <= '0;
      end else begin
         lvl_q   <= lvl_d;
         tally_q <= tally_d;
      end
   end
`else
   assign lvl_s = '0;
`endif

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_out
      assign steer[2*ch +: 2] = phase_q[ch];
   end

   assign moving = moving_q;

endmodule

// File: tb/tb_joy2quad_multi.sv
// Randomised bench for joy2quad_multi: every edge is compared against a position/elapsed-time model.
module tb_joy2quad_multi;

   localparam int CH = 2;
   localparam int DW = 16;
   localparam int AS = 4;
   localparam int AM = 2;
`ifdef JOY2QUAD_ACCEL_EN
   localparam bit ACC = 1'b1;
`else
   localparam bit ACC = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RESET;
   logic [DW-1:0]   clkdiv;
   logic [CH-1:0]   left;
   logic [CH-1:0]   right;
   logic [2*CH-1:0] steer;
   logic [CH-1:0]   moving;

   always #5 CLK = ~CLK;

   joy2quad_multi #(
      .CHANNELS(CH), .DIV_W(DW), .ACCEL_STEPS(AS), .ACCEL_MAX(AM)
   ) dut (
      .CLK(CLK), .RESET(RESET), .clkdiv(clkdiv), .left(left), .right(right),
      .steer(steer), .moving(moving)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int m_dir   [CH];
   int m_prev  [CH];
   int m_elap  [CH];
   int m_pos   [CH];
   int m_steps [CH];
   logic [1:0] gray [4];

   function automatic int dir_of(input logic l, input logic r);
      if (r && !l) return 1;
      else if (l && !r) return -1;
      else return 0;
   endfunction

   // Step period for a run that has already made 'steps' steps.
   function automatic int period(input int steps);
      int lvl;
      int p;
      lvl = ACC ? (steps / AS) : 0;
      if (lvl > AM) lvl = AM;
      p = int'(clkdiv) >> lvl;
      if (p < 1) p = 1;
      return p;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_dir[c] = 0; m_prev[c] = 0; m_elap[c] = 0; m_pos[c] = 0; m_steps[c] = 0;
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < CH; c++) begin
         if (m_dir[c] == 0 || m_dir[c] != m_prev[c]) begin
            m_elap[c]  = 0;
            m_steps[c] = 0;
         end else begin
            m_elap[c]++;
            if (m_elap[c] >= period(m_steps[c])) begin
               m_pos[c]  = (m_pos[c] + m_dir[c] + 4) % 4;
               m_elap[c] = 0;
               m_steps[c]++;
            end
         end
         m_prev[c] = m_dir[c];
         m_dir[c]  = dir_of(left[c], right[c]);
      end
   endtask

   task automatic compare_outputs(input string tag);
      logic [2*CH-1:0] exp_steer;
      logic [CH-1:0]   exp_moving;
      for (int c = 0; c < CH; c++) begin
         exp_steer[2*c +: 2] = gray[m_pos[c]];
         exp_moving[c]       = (m_dir[c] != 0);
      end
      check({tag, ".steer"}, 32'(steer), 32'(exp_steer));
      check({tag, ".moving"}, 32'(moving), 32'(exp_moving));
   endtask

   task automatic tick(input string tag);
      @(posedge CLK);
      if (RESET) model_reset();
      else model_edge();
      #1;
      compare_outputs(tag);
   endtask

   task automatic hold(input string tag, input logic [CH-1:0] l, input logic [CH-1:0] r,
                       input int cd, input int n);
      left   = l;
      right  = r;
      clkdiv = DW'(cd);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   initial begin
      gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
      model_reset();
      RESET  = 1'b1;
      left   = '0;
      right  = '0;
      clkdiv = DW'(4);
      #1;
      compare_outputs("reset_async");
      tick("reset_hold");
      tick("reset_hold");
      RESET = 1'b0;

      hold("cw_p4", 2'b00, 2'b01, 4, 20);
      hold("reverse", 2'b01, 2'b00, 4, 12);
      hold("both", 2'b01, 2'b01, 4, 6);
      hold("release", 2'b00, 2'b00, 4, 3);
      hold("p_zero", 2'b00, 2'b01, 0, 8);
      hold("p_1000", 2'b00, 2'b01, 1000, 502);
      hold("p_shrink", 2'b00, 2'b01, 3, 10);
      hold("indep", 2'b10, 2'b01, 2, 8);
      hold("idle", 2'b00, 2'b00, 2, 2);
      hold("accel", 2'b00, 2'b01, 8, 80);
      hold("accel_rel", 2'b00, 2'b00, 8, 3);
      hold("accel_again", 2'b00, 2'b01, 8, 20);

      // Reset mid-rotation must clear outputs before the next edge.
      hold("pre_reset", 2'b10, 2'b01, 1, 5);
      #2;
      RESET = 1'b1;
      model_reset();
      #1;
      compare_outputs("reset_mid");
      tick("reset_mid_hold");
      tick("reset_mid_hold");
      RESET = 1'b0;

      for (int s = 0; s < 300; s++) begin
         hold("random", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 6), $urandom_range(1, 12));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
